// File: rtl/frame_packer.sv
// frame_packer: drains the buffer stage's read port, groups FRAME_LEN words
// into a frame and sends them on a valid/ready stream. Each frame ends with a
// checksum beat (modular sum of the frame's data words), flagged by m_last.
//
// Stream handshake: a beat transfers on a rising edge where m_valid and
// m_ready are both 1; once m_valid is raised, m_data and m_last hold until
// that transfer. The buffer side has no handshake: a buf_rd_en cycle returns
// buf_data exactly one cycle later, and that word is always accepted.
module frame_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  buf_empty,
  output logic                  buf_rd_en,
  input  logic [DATA_WIDTH-1:0] buf_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [15:0]           frames_sent,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam logic [1:0] ST_DATA  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_SUM   = 2'd2;

  localparam logic [7:0] FL      = 8'(FRAME_LEN);
  localparam logic [7:0] LAST_TX = 8'(FRAME_LEN - 1);

  logic [1:0]            state_q, state_d;
  logic [7:0]            rd_cnt_q, rd_cnt_d;
  logic [7:0]            tx_cnt_q, tx_cnt_d;
  logic [1:0]            occ_q, occ_d;
  logic                  pending_q;
  logic [DATA_WIDTH-1:0] mem0_q, mem0_d;   // FIFO head
  logic [DATA_WIDTH-1:0] mem1_q, mem1_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [15:0]           frames_q, frames_d;

  logic       data_valid;
  logic       fire;
  logic       pop;
  logic       push;
  logic       sum_fire;
  logic [2:0] level;

  // Output stage, handshake decode and read-issue decision
  always_comb begin
    data_valid = (state_q != ST_SUM) && (occ_q != 2'd0);
    m_valid    = data_valid || (state_q == ST_SUM);
    m_last     = (state_q == ST_SUM);
    m_data     = '0;
    if (state_q == ST_SUM)    m_data = sum_q;
    else if (occ_q != 2'd0)   m_data = mem0_q;
    fire       = m_valid && m_ready;
    pop        = fire && data_valid;
    sum_fire   = fire && (state_q == ST_SUM);
    push       = pending_q;
    // Slots that will be taken once every in-flight read has landed
    level      = {1'b0, occ_q} + {2'b00, pending_q} - {2'b00, pop};
    buf_rd_en  = !rst && (state_q == ST_DATA) && !buf_empty &&
                 (rd_cnt_q < FL) && (level < 3'd2);
    busy        = (state_q != ST_DATA) || (rd_cnt_q != 8'd0) ||
                  (occ_q != 2'd0) || pending_q;
    frames_sent = frames_q;
    dbg_state   = state_q;
  end

  // Skid FIFO next state: simultaneous push and pop keep occupancy constant
  always_comb begin
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    occ_d  = occ_q + {1'b0, push} - {1'b0, pop};
    case ({push, pop})
      2'b01: mem0_d = mem1_q;
      2'b10: begin
        if (occ_q == 2'd0) mem0_d = buf_data;
        else               mem1_d = buf_data;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          mem0_d = buf_data;
        end else begin
          mem0_d = mem1_q;
          mem1_d = buf_data;
        end
      end
      default: ;
    endcase
  end

  // Frame sequencing, counters and checksum accumulation on FIFO write
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    tx_cnt_d = tx_cnt_q;
    sum_d    = sum_q;
    frames_d = frames_q;
    if (buf_rd_en) rd_cnt_d = rd_cnt_q + 8'd1;
    if (pop)       tx_cnt_d = tx_cnt_q + 8'd1;
    if (push)      sum_d    = sum_q + buf_data;
    case (state_q)
      ST_DATA:  if (buf_rd_en && (rd_cnt_q + 8'd1 == FL)) state_d = ST_DRAIN;
      ST_DRAIN: if (pop && (tx_cnt_q == LAST_TX))          state_d = ST_SUM;
      ST_SUM: begin
        if (sum_fire) begin
          state_d  = ST_DATA;
          rd_cnt_d = '0;
          tx_cnt_d = '0;
          sum_d    = '0;
          frames_d = frames_q + 16'd1;
        end
      end
      default: state_d = ST_DATA;
    endcase
  end

  // FIFO storage and in-flight read flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem0_q    <= '0;
      mem1_q    <= '0;
      occ_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      mem0_q    <= mem0_d;
      mem1_q    <= mem1_d;
      occ_q     <= occ_d;
      pending_q <= buf_rd_en;
    end
  end

  // FSM state, counters, checksum and frame count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_DATA;
      rd_cnt_q <= '0;
      tx_cnt_q <= '0;
      sum_q    <= '0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      tx_cnt_q <= tx_cnt_d;
      sum_q    <= sum_d;
      frames_q <= frames_d;
    end
  end

endmodule

// File: tb/tb_frame_packer.sv
// Bench for frame_packer: a FRAME_LEN=4 instance driven by a buffer model and
// checked by a scoreboard, plus a FRAME_LEN=1 instance for back-to-back frames.
module tb_frame_packer;

  logic        clk;
  logic        rst;

  logic        buf_empty, buf_rd_en, m_valid, m_ready, m_last, busy;
  logic [31:0] buf_data, m_data;
  logic [15:0] frames_sent;
  logic [1:0]  dbg_state;

  logic        b_empty1, b_rd1, m_valid1, m_ready1, m_last1, busy1;
  logic [31:0] b_data1, m_data1;
  logic [15:0] fs1;
  logic [1:0]  dbg1;

  int n_cmp = 0;
  int n_err = 0;

  logic [32:0] exp_q[$];
  logic [31:0] sup_q[$];
  int          beat_cyc_q[$];
  bit          starve = 1'b0;
  int          cyc = 0;
  int          rd_total = 0;
  int          first_rd_cyc = -1;
  int          first_v_cyc = -1;

  frame_packer #(.DATA_WIDTH(32), .FRAME_LEN(4)) dut (
    .clk(clk), .rst(rst), .buf_empty(buf_empty), .buf_rd_en(buf_rd_en),
    .buf_data(buf_data), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .frames_sent(frames_sent),
    .busy(busy), .dbg_state(dbg_state)
  );

  frame_packer #(.DATA_WIDTH(32), .FRAME_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .buf_empty(b_empty1), .buf_rd_en(b_rd1),
    .buf_data(b_data1), .m_data(m_data1), .m_valid(m_valid1),
    .m_ready(m_ready1), .m_last(m_last1), .frames_sent(fs1),
    .busy(busy1), .dbg_state(dbg1)
  );

  // Clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Buffer model and output scoreboard for the FRAME_LEN=4 instance
  initial begin
    logic        rd_seen;
    logic [31:0] nxt;
    logic        hold_pend;
    logic [32:0] hold_v;
    logic [32:0] e;
    rd_seen   = 1'b0;
    nxt       = '0;
    hold_pend = 1'b0;
    hold_v    = '0;
    buf_data  = '0;
    buf_empty = 1'b1;
    forever begin
      @(negedge clk);
      rd_seen = buf_rd_en;
      if (rd_seen) begin
        rd_total++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        nxt = (sup_q.size() != 0) ? sup_q.pop_front() : 32'hBAD0BAD0;
      end
      if (rst) begin
        hold_pend = 1'b0;
      end else begin
        if (m_valid && first_v_cyc < 0) first_v_cyc = cyc;
        if (hold_pend) begin
          n_cmp++;
          if (!m_valid || {m_last, m_data} !== hold_v) begin
            n_err++;
            $display("FAIL hold_stable: got valid=%0b last=%0b data=%h, expected valid=1 last=%0b data=%h",
                     m_valid, m_last, m_data, hold_v[32], hold_v[31:0]);
          end
        end
        if (m_valid && m_ready) begin
          beat_cyc_q.push_back(cyc);
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_beat: got last=%0b data=%h, expected no beat", m_last, m_data);
          end else begin
            e = exp_q.pop_front();
            if ({m_last, m_data} !== e) begin
              n_err++;
              $display("FAIL beat: got last=%0b data=%h, expected last=%0b data=%h",
                       m_last, m_data, e[32], e[31:0]);
            end
          end
        end
        hold_pend = m_valid && !m_ready;
        hold_v    = {m_last, m_data};
      end
      @(posedge clk);
      #1;
      buf_data  = rd_seen ? nxt : $urandom;
      buf_empty = starve || (sup_q.size() == 0);
    end
  end

  // Queue one frame: all data beats plus checksum as expected, n_sup words supplied
  task automatic load_frame(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3,
                            input int n_sup);
    logic [31:0] w[4];
    logic [31:0] s;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      s = s + w[i];
      exp_q.push_back({1'b0, w[i]});
      if (i < n_sup) sup_q.push_back(w[i]);
    end
    exp_q.push_back({1'b1, s});
  endtask

  // Bounded wait for the scoreboard to empty, then one cycle for frames_sent
  task automatic wait_drain(input string nm, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_timeout: got %0d beats outstanding, expected 0", nm, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; m_ready = 1'b1; m_ready1 = 1'b1;
    b_empty1 = 1'b1; b_data1 = '0;
    starve = 1'b0;
    sup_q.push_back(32'h1234_5678);
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({buf_rd_en, m_valid, m_last, busy} !== 4'b0000 || m_data !== 32'd0 || frames_sent !== 16'd0) begin
      n_err++;
      $display("FAIL reset_values: got rd=%0b v=%0b last=%0b busy=%0b data=%h frames=%0d, expected all 0",
               buf_rd_en, m_valid, m_last, busy, m_data, frames_sent);
    end
    sup_q.delete();
    starve = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    starve = 1'b0;
  endtask

  task automatic test_basic();
    @(posedge clk); #2;
    beat_cyc_q.delete();
    first_rd_cyc = -1; first_v_cyc = -1;
    load_frame(32'd1, 32'd2, 32'd3, 32'd4, 4);
    wait_drain("basic", 40);
    n_cmp++;
    if (first_v_cyc - first_rd_cyc != 2) begin
      n_err++;
      $display("FAIL basic_latency: got %0d cycles, expected 2", first_v_cyc - first_rd_cyc);
    end
    n_cmp++;
    if (beat_cyc_q.size() != 5 || beat_cyc_q[4] - beat_cyc_q[0] != 4) begin
      n_err++;
      $display("FAIL basic_throughput: got %0d beats, expected 5 consecutive", beat_cyc_q.size());
    end
    n_cmp++;
    if (frames_sent !== 16'd1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_frames: got frames=%0d busy=%0b, expected frames=1 busy=0", frames_sent, busy);
    end
  endtask

  task automatic test_checksum_wrap();
    @(posedge clk); #2;
    load_frame(32'hFFFF_FFFF, 32'd1, 32'd2, 32'd3, 4);
    wait_drain("wrap", 40);
    n_cmp++;
    if (frames_sent !== 16'd2) begin
      n_err++;
      $display("FAIL wrap_frames: got %0d, expected 2", frames_sent);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w0;
    int rd0;
    w0 = 32'($urandom_range(1000, 60000));
    @(posedge clk); #2;
    m_ready = 1'b0;
    rd0 = rd_total;
    load_frame(w0, $urandom, $urandom, $urandom, 4);
    repeat (8) @(negedge clk);
    n_cmp++;
    if (rd_total - rd0 != 2 || buf_rd_en !== 1'b0) begin
      n_err++;
      $display("FAIL bp_reads: got %0d reads rd_en=%0b, expected 2 reads rd_en=0", rd_total - rd0, buf_rd_en);
    end
    n_cmp++;
    if (m_valid !== 1'b1 || m_data !== w0) begin
      n_err++;
      $display("FAIL bp_head: got valid=%0b data=%h, expected valid=1 data=%h", m_valid, m_data, w0);
    end
    @(posedge clk); #2; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2; m_ready = 1'b0;
    repeat (5) @(posedge clk);
    #2; m_ready = 1'b1;
    wait_drain("backpressure", 40);
    n_cmp++;
    if (frames_sent !== 16'd3) begin
      n_err++;
      $display("FAIL bp_frames: got %0d, expected 3", frames_sent);
    end
  endtask

  task automatic test_starvation();
    @(posedge clk); #2;
    beat_cyc_q.delete();
    load_frame(32'd10, 32'd20, 32'd30, 32'd40, 2);
    repeat (12) @(negedge clk);
    n_cmp++;
    if (m_valid !== 1'b0 || busy !== 1'b1 || beat_cyc_q.size() != 2) begin
      n_err++;
      $display("FAIL starve_state: got valid=%0b busy=%0b beats=%0d, expected valid=0 busy=1 beats=2",
               m_valid, busy, beat_cyc_q.size());
    end
    @(posedge clk); #2;
    sup_q.push_back(32'd30);
    sup_q.push_back(32'd40);
    wait_drain("starvation", 40);
    n_cmp++;
    if (frames_sent !== 16'd4) begin
      n_err++;
      $display("FAIL starve_frames: got %0d, expected 4", frames_sent);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    @(posedge clk); #2;
    beat_cyc_q.delete();
    load_frame(32'd11, 32'd22, 32'd33, 32'd44, 4);
    k = 0;
    while (beat_cyc_q.size() < 2 && k < 30) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (beat_cyc_q.size() < 2) begin
      n_err++;
      $display("FAIL rstmid_timeout: got %0d beats, expected 2", beat_cyc_q.size());
    end
    #2;
    rst = 1'b1;
    starve = 1'b1;
    sup_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({buf_rd_en, m_valid, m_last, busy} !== 4'b0000 || m_data !== 32'd0 || frames_sent !== 16'd0) begin
      n_err++;
      $display("FAIL rstmid_values: got rd=%0b v=%0b last=%0b busy=%0b data=%h frames=%0d, expected all 0",
               buf_rd_en, m_valid, m_last, busy, m_data, frames_sent);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    starve = 1'b0;
    load_frame(32'd5, 32'd6, 32'd7, 32'd8, 4);
    wait_drain("post_reset", 40);
    n_cmp++;
    if (frames_sent !== 16'd1) begin
      n_err++;
      $display("FAIL rstmid_frames: got %0d, expected 1", frames_sent);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] s1[$];
    logic [32:0] e1[$];
    logic [32:0] e;
    logic [31:0] nxt;
    logic        rd;
    int          lc, dc, k;
    s1 = '{32'd7, 32'd9};
    e1 = '{{1'b0, 32'd7}, {1'b1, 32'd7}, {1'b0, 32'd9}, {1'b1, 32'd9}};
    lc = -1; dc = -1; nxt = '0;
    @(posedge clk); #2;
    m_ready1 = 1'b1;
    b_empty1 = 1'b0;
    k = 0;
    while (e1.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
      rd = b_rd1;
      if (rd) nxt = (s1.size() != 0) ? s1.pop_front() : 32'hBAD1BAD1;
      if (m_valid1 && m_ready1) begin
        n_cmp++;
        if (e1.size() == 0) begin
          n_err++;
          $display("FAIL b2b_unexpected: got last=%0b data=%h, expected no beat", m_last1, m_data1);
        end else begin
          e = e1.pop_front();
          if ({m_last1, m_data1} !== e) begin
            n_err++;
            $display("FAIL b2b_beat: got last=%0b data=%h, expected last=%0b data=%h",
                     m_last1, m_data1, e[32], e[31:0]);
          end
          if (e[32] && lc < 0) lc = cyc;
          if (!e[32] && lc >= 0 && dc < 0) dc = cyc;
        end
      end
      @(posedge clk); #2;
      b_data1  = rd ? nxt : $urandom;
      b_empty1 = (s1.size() == 0);
    end
    @(negedge clk);
    n_cmp++;
    if (e1.size() != 0 || fs1 !== 16'd2) begin
      n_err++;
      $display("FAIL b2b_frames: got %0d frames with %0d beats left, expected 2 frames 0 left", fs1, e1.size());
    end
    n_cmp++;
    if (dc - lc != 3) begin
      n_err++;
      $display("FAIL b2b_gap: got %0d cycles, expected 3", dc - lc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_checksum_wrap();
    test_backpressure();
    test_starvation();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover: got %0d expected beats pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
